// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: round-robin sharing of one memory bus between fetch and data ports with response timeout
module core_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW/8-1:0] d_bytemask,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_bytemask,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0] state;
  logic last_d, own_d, pick_d, idle, done;
  logic [CW-1:0] cnt;
  always_comb begin
    idle = rst && state == IDLE;
    pick_d = d_req && (!i_req || !last_d);
    i_gnt = idle && i_req && !pick_d;
    d_gnt = idle && pick_d;
    mem_req = state == ADDR;
    done = mem_rvalid || cnt == TO_LAST;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last_d <= 1'b0;
      own_d <= 1'b0;
      cnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_bytemask <= '0;
      i_rvalid <= 1'b0;
      i_rdata <= '0;
      i_err <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata <= '0;
      d_err <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      i_err <= 1'b0;
      d_rvalid <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: if (i_req || d_req) begin
          own_d <= pick_d;
          last_d <= pick_d;
          mem_we <= pick_d && d_we;
          mem_addr <= pick_d ? d_addr : i_addr;
          mem_wdata <= pick_d && d_we ? d_wdata : '0;
          mem_bytemask <= pick_d && d_we ? d_bytemask : '0;
          state <= ADDR;
        end
        ADDR: if (mem_gnt) begin
          cnt <= '0;
          state <= mem_we ? IDLE : RESP;
          d_rvalid <= mem_we;
          d_rdata <= mem_we ? '0 : d_rdata;
        end
        RESP: if (done) begin
          state <= IDLE;
          i_rvalid <= !own_d;
          d_rvalid <= own_d;
          i_err <= !own_d && !mem_rvalid;
          d_err <= own_d && !mem_rvalid;
          i_rdata <= own_d ? i_rdata : (mem_rvalid ? mem_rdata : '0);
          d_rdata <= own_d ? (mem_rvalid ? mem_rdata : '0) : d_rdata;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed self-checking bench for core_bus_arbiter
module tb_core_bus_arbiter;
  logic clk = 0, rst = 0;
  logic i_req = 0, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr = 0, i_rdata;
  logic d_req = 0, d_we = 0, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic [3:0] d_bytemask = 0, mem_bytemask;
  logic mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  int checks = 0, errors = 0;
  core_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_bytemask(d_bytemask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bytemask(mem_bytemask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    i_req = 1; d_req = 1;
    tick; #1;
    chk("t1_i_gnt", i_gnt, 0);
    chk("t1_d_gnt", d_gnt, 0);
    tick; #1;
    chk("t1_i_gnt2", i_gnt, 0);
    chk("t1_d_gnt2", d_gnt, 0);
    chk("t1_mem", {mem_req, mem_we, mem_addr, mem_wdata[3:0], mem_bytemask}, 0);
    chk("t1_resp", {i_rvalid, i_err, d_rvalid, d_err}, 0);
    chk("t1_data", {i_rdata, d_rdata}, 0);
    rst = 1; i_req = 0; d_req = 0;
    tick;
    i_req = 1; i_addr = 32'h100; #1;
    chk("t2_i_gnt", i_gnt, 1);
    chk("t2_d_gnt", d_gnt, 0);
    tick;
    i_req = 0; mem_gnt = 1; #1;
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_we_mask", {mem_we, mem_bytemask}, 0);
    chk("t2_no_gnt_addr", i_gnt, 0);
    tick;
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("t2_resp_mem_req", mem_req, 0);
    chk("t2_early_rvalid", i_rvalid, 0);
    tick;
    mem_rvalid = 0; #1;
    chk("t2_i_rvalid", i_rvalid, 1);
    chk("t2_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("t2_i_err", i_err, 0);
    chk("t2_d_rvalid", d_rvalid, 0);
    tick; #1;
    chk("t2_pulse", i_rvalid, 0);
    rst = 0; tick; rst = 1;
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h200; d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_d_gnt", d_gnt, (k % 2 == 0));
      chk("t3_i_gnt", i_gnt, (k % 2 == 1));
      if (k > 0) begin
        chk("t3_prev_rvalid", (k % 2 == 1) ? d_rvalid : i_rvalid, 1);
        chk("t3_prev_rdata", (k % 2 == 1) ? d_rdata : i_rdata, 32'hA0 + k - 1);
      end
      tick;
      mem_gnt = 1; #1;
      chk("t3_mem_addr", mem_addr, (k % 2 == 0) ? 32'h300 : 32'h200);
      chk("t3_gnt_in_addr", {i_gnt, d_gnt}, 0);
      tick;
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA0 + k;
      tick;
      mem_rvalid = 0;
    end
    #1;
    chk("t3_last_rvalid", i_rvalid, 1);
    chk("t3_last_rdata", i_rdata, 32'hA3);
    chk("t3_last_d_quiet", d_rvalid, 0);
    i_req = 0; d_req = 0;
    tick; tick;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h11223344; d_bytemask = 4'b0011; #1;
    chk("t4_d_gnt", d_gnt, 1);
    tick;
    d_req = 0; d_we = 0; d_addr = 32'hFFFF; d_wdata = 0; d_bytemask = 4'hF;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t4_stall_req", mem_req, 1);
      chk("t4_stall_payload", {mem_we, mem_addr, mem_wdata, mem_bytemask}, {1'b1, 32'h20, 32'h11223344, 4'b0011});
      chk("t4_stall_rvalid", d_rvalid, 0);
      tick;
    end
    mem_gnt = 1; #1;
    chk("t4_gnt_req", mem_req, 1);
    tick;
    mem_gnt = 0; #1;
    chk("t4_d_rvalid", d_rvalid, 1);
    chk("t4_d_rdata_err", {d_rdata, d_err}, 0);
    chk("t4_i_quiet", i_rvalid, 0);
    chk("t4_idle_req", mem_req, 0);
    tick; #1;
    chk("t4_pulse", d_rvalid, 0);
    i_req = 1; i_addr = 32'h40; #1;
    chk("t5_i_gnt", i_gnt, 1);
    tick;
    i_req = 0; mem_gnt = 1;
    tick;
    mem_gnt = 0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("t5_wait_rvalid", i_rvalid, 0);
      chk("t5_wait_req", mem_req, 0);
      tick;
    end
    d_req = 1; d_we = 0; d_addr = 32'h44; #1;
    chk("t5_err_rvalid", i_rvalid, 1);
    chk("t5_err", i_err, 1);
    chk("t5_err_rdata", i_rdata, 0);
    chk("t5_next_gnt", d_gnt, 1);
    tick;
    d_req = 0; mem_gnt = 1; #1;
    chk("t5_once", {i_rvalid, i_err}, 0);
    chk("t5_d_addr", mem_addr, 32'h44);
    tick;
    mem_gnt = 0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t5b_wait", d_rvalid, 0);
      tick;
    end
    mem_rvalid = 1; mem_rdata = 32'h55;
    tick;
    mem_rvalid = 0; #1;
    chk("t5b_rvalid", d_rvalid, 1);
    chk("t5b_err", d_err, 0);
    chk("t5b_rdata", d_rdata, 32'h55);
    tick; #1;
    chk("t5b_pulse", d_rvalid, 0);
    i_req = 1; i_addr = 32'h80; #1;
    chk("t6_i_gnt", i_gnt, 1);
    tick;
    i_req = 0; mem_gnt = 1;
    tick;
    mem_gnt = 0; rst = 0;
    tick;
    rst = 1; mem_rvalid = 1; mem_rdata = 32'h77; #1;
    chk("t6_rst_rvalid", i_rvalid, 0);
    chk("t6_rst_req", mem_req, 0);
    tick;
    mem_rvalid = 0; d_req = 1; #1;
    chk("t6_late_ignored", {i_rvalid, d_rvalid, i_err, d_err}, 0);
    chk("t6_idle_gnt", d_gnt, 1);
    tick;
    d_req = 0;
    tick; tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
